// File: rtl/uart_rx_pkt_ctrl.sv
// Packet controller behind uart_rx: parses SOF/LEN/payload/checksum frames, buffers and streams verified payload.
// Optional statistics counters (PKT_GOOD_CNT / PKT_ERR_CNT) are compiled in with UART_PKT_STATS_EN.
module uart_rx_pkt_ctrl #(
   parameter int unsigned CLK_FREQ     = 125_000_000,
   parameter int unsigned BAUD         = 9600,
   parameter int unsigned MAX_LEN      = 16,
   parameter logic [7:0]  SOF_BYTE     = 8'hAA,
   parameter int unsigned TIMEOUT_BITS = 20
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        PAR_SEL,
   input  logic [7:0]  RX_DATA,
   input  logic        RX_DATA_RDY,
   input  logic        RX_PAR_ERR,
   output logic        PARITY,
   output logic [7:0]  PKT_DATA,
   output logic        PKT_VALID,
   input  logic        PKT_READY,
   output logic        PKT_LAST,
   output logic [7:0]  PKT_LEN,
   output logic        PKT_ERR,
   output logic [1:0]  ERR_CODE,
   output logic [2:0]  fsm_state
`ifdef UART_PKT_STATS_EN
   ,
   output logic [15:0] PKT_GOOD_CNT,
   output logic [15:0] PKT_ERR_CNT
`endif
);
   localparam int unsigned TIMEOUT_CYC = (CLK_FREQ / BAUD) * TIMEOUT_BITS;
   localparam int unsigned TMO_W       = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int unsigned IDX_W       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
   localparam logic [IDX_W-1:0] IDX_ZERO  = IDX_W'(0);
   localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LEN     = 3'd1,
      S_PAYLOAD = 3'd2,
      S_CSUM    = 3'd3,
      S_DRAIN   = 3'd4
   } state_t;

   state_t           r_state, w_next_state;
   logic             r_parity;
   logic [7:0]       r_len, r_csum, r_data;
   logic [IDX_W-1:0] r_idx;
   logic [TMO_W-1:0] r_tmo;
   logic [7:0]       r_buf [MAX_LEN];
   logic             r_valid, r_last, r_err;
   logic [1:0]       r_err_code;
   logic             w_tmo_exp, w_len_ok, w_idx_last, w_csum_ok, w_xfer, w_wr, w_err, w_counting;
   logic [1:0]       w_err_code;
   logic [7:0]       w_csum_sum;
   logic [IDX_W-1:0] w_idx_nx;

   assign w_tmo_exp  = (r_tmo == TMO_LAST);
   assign w_len_ok   = (RX_DATA != 8'd0) && (RX_DATA <= MAX_LEN_B);
   assign w_idx_last = (8'(r_idx) == (r_len - 8'd1));
   assign w_csum_sum = r_csum + RX_DATA;
   assign w_csum_ok  = (w_csum_sum == 8'd0);
   assign w_xfer     = r_valid & PKT_READY;
   assign w_idx_nx   = r_idx + IDX_ONE;
   assign w_wr       = (r_state == S_PAYLOAD) && RX_DATA_RDY && !RX_PAR_ERR;
   assign w_counting = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CSUM);

   // Next-state and error decode; parity error outranks length/checksum, and a byte outranks timeout.
   always_comb begin
      w_next_state = r_state;
      w_err        = 1'b0;
      w_err_code   = 2'b00;
      case (r_state)
         S_IDLE: begin
            if (RX_DATA_RDY && !RX_PAR_ERR && (RX_DATA == SOF_BYTE)) w_next_state = S_LEN;
            else                                                    w_next_state = S_IDLE;
         end
         S_LEN, S_PAYLOAD, S_CSUM: begin
            if (RX_DATA_RDY && RX_PAR_ERR) begin
               w_err        = 1'b1;
               w_err_code   = 2'b00;
               w_next_state = S_IDLE;
            end else if (RX_DATA_RDY) begin
               if (r_state == S_LEN) begin
                  if (w_len_ok) begin
                     w_next_state = S_PAYLOAD;
                  end else begin
                     w_err        = 1'b1;
                     w_err_code   = 2'b01;
                     w_next_state = S_IDLE;
                  end
               end else if (r_state == S_PAYLOAD) begin
                  if (w_idx_last) w_next_state = S_CSUM;
                  else            w_next_state = S_PAYLOAD;
               end else begin
                  if (w_csum_ok) begin
                     w_next_state = S_DRAIN;
                  end else begin
                     w_err        = 1'b1;
                     w_err_code   = 2'b11;
                     w_next_state = S_IDLE;
                  end
               end
            end else if (w_tmo_exp) begin
               w_err        = 1'b1;
               w_err_code   = 2'b10;
               w_next_state = S_IDLE;
            end else begin
               w_next_state = r_state;
            end
         end
         S_DRAIN: begin
            if (w_xfer && r_last) w_next_state = S_IDLE;
            else                  w_next_state = S_DRAIN;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) r_state <= S_IDLE;
      else      r_state <= w_next_state;
   end

   // Inter-byte timeout: only runs while a frame is being received.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)                                       r_tmo <= '0;
      else if (w_counting && !RX_DATA_RDY && !w_tmo_exp) r_tmo <= r_tmo + TMO_W'(1);
      else                                            r_tmo <= '0;
   end

   always_ff @(posedge CLK) begin
      if (w_wr) r_buf[r_idx] <= RX_DATA;
   end

   // Frame datapath and the registered stream/error outputs.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_parity   <= 1'b0;
         r_len      <= 8'd0;
         r_csum     <= 8'd0;
         r_idx      <= IDX_ZERO;
         r_valid    <= 1'b0;
         r_data     <= 8'd0;
         r_last     <= 1'b0;
         r_err      <= 1'b0;
         r_err_code <= 2'b00;
      end else begin
         r_err <= w_err;
         if (w_err) r_err_code <= w_err_code;
         if (r_state == S_IDLE) r_parity <= PAR_SEL;
         case (r_state)
            S_IDLE: begin
               if (w_next_state == S_LEN) r_csum <= 8'd0;
            end
            S_LEN: begin
               if (w_next_state == S_PAYLOAD) begin
                  r_len  <= RX_DATA;
                  r_csum <= RX_DATA;
                  r_idx  <= IDX_ZERO;
               end
            end
            S_PAYLOAD: begin
               if (w_wr) begin
                  r_csum <= w_csum_sum;
                  r_idx  <= w_idx_nx;
               end
            end
            S_CSUM: begin
               if (w_next_state == S_DRAIN) begin
                  r_valid <= 1'b1;
                  r_data  <= r_buf[IDX_ZERO];
                  r_last  <= (r_len == 8'd1);
                  r_idx   <= IDX_ZERO;
               end
            end
            S_DRAIN: begin
               if (w_xfer) begin
                  if (r_last) begin
                     r_valid <= 1'b0;
                     r_last  <= 1'b0;
                  end else begin
                     r_idx  <= w_idx_nx;
                     r_data <= r_buf[w_idx_nx];
                     r_last <= (8'(w_idx_nx) == (r_len - 8'd1));
                  end
               end
            end
            default: ;
         endcase
      end
   end

`ifdef UART_PKT_STATS_EN
   logic [15:0] r_good_cnt, r_err_cnt;

   // Saturating packet statistics.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_good_cnt <= 16'd0;
         r_err_cnt  <= 16'd0;
      end else begin
         if ((r_state == S_DRAIN) && w_xfer && r_last && (r_good_cnt != 16'hFFFF))
            r_good_cnt <= r_good_cnt + 16'd1;
         if (w_err && (r_err_cnt != 16'hFFFF))
            r_err_cnt <= r_err_cnt + 16'd1;
      end
   end

   assign PKT_GOOD_CNT = r_good_cnt;
   assign PKT_ERR_CNT  = r_err_cnt;
`endif

   assign PARITY    = r_parity;
   assign PKT_DATA  = r_data;
   assign PKT_VALID = r_valid;
   assign PKT_LAST  = r_last;
   assign PKT_LEN   = r_len;
   assign PKT_ERR   = r_err;
   assign ERR_CODE  = r_err_code;
   assign fsm_state = r_state;
endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Table-driven bench for uart_rx_pkt_ctrl with a shortened timeout (40 cycles).
module tb_uart_rx_pkt_ctrl;
   localparam int TC = 40;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       PAR_SEL = 1'b0;
   logic [7:0] RX_DATA = 8'd0;
   logic       RX_DATA_RDY = 1'b0;
   logic       RX_PAR_ERR = 1'b0;
   logic       PKT_READY = 1'b0;
   logic       PARITY, PKT_VALID, PKT_LAST, PKT_ERR;
   logic [7:0] PKT_DATA, PKT_LEN;
   logic [1:0] ERR_CODE;
   logic [2:0] fsm_state;
`ifdef UART_PKT_STATS_EN
   logic [15:0] good_cnt, err_cnt;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       rdy;
      logic [7:0] d;
      logic       pe, rd, ps;
      logic [2:0] st;
      logic       v;
      logic [7:0] pd;
      logic       l, e;
      logic [1:0] ec;
      logic [7:0] len;
      logic       par;
   } vec_t;

   vec_t tbl[$];

   uart_rx_pkt_ctrl #(
      .CLK_FREQ(1000), .BAUD(100), .MAX_LEN(16), .SOF_BYTE(8'hAA), .TIMEOUT_BITS(4)
   ) dut (
      .CLK(CLK), .RST(RST), .PAR_SEL(PAR_SEL), .RX_DATA(RX_DATA), .RX_DATA_RDY(RX_DATA_RDY),
      .RX_PAR_ERR(RX_PAR_ERR), .PARITY(PARITY), .PKT_DATA(PKT_DATA), .PKT_VALID(PKT_VALID),
      .PKT_READY(PKT_READY), .PKT_LAST(PKT_LAST), .PKT_LEN(PKT_LEN), .PKT_ERR(PKT_ERR),
      .ERR_CODE(ERR_CODE), .fsm_state(fsm_state)
`ifdef UART_PKT_STATS_EN
      , .PKT_GOOD_CNT(good_cnt), .PKT_ERR_CNT(err_cnt)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic rdy, input logic [7:0] d, input logic pe, input logic rd, input logic ps);
      RX_DATA_RDY = rdy; RX_DATA = d; RX_PAR_ERR = pe; PKT_READY = rd; PAR_SEL = ps;
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic send(input logic [7:0] d);
      drive(1'b1, d, 1'b0, 1'b0, 1'b0);
      step();
      drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
   endtask

   function automatic vec_t mk(input int rdy, input int d, input int pe, input int rd, input int ps,
                               input int st, input int v, input int pd, input int l, input int e,
                               input int ec, input int len, input int par);
      vec_t r;
      r.rdy = 1'(rdy); r.d = 8'(d); r.pe = 1'(pe); r.rd = 1'(rd); r.ps = 1'(ps);
      r.st = 3'(st); r.v = 1'(v); r.pd = 8'(pd); r.l = 1'(l); r.e = 1'(e);
      r.ec = 2'(ec); r.len = 8'(len); r.par = 1'(par);
      return r;
   endfunction

   initial begin
      int hit;
      // good packet, ready held high
      tbl.push_back(mk(1,8'hAA,0,1,0, 1,0,0,0,0,0, 0,0));
      tbl.push_back(mk(1,8'h03,0,1,0, 2,0,0,0,0,0, 3,0));
      tbl.push_back(mk(1,8'h11,0,1,0, 2,0,0,0,0,0, 3,0));
      tbl.push_back(mk(1,8'h22,0,1,0, 2,0,0,0,0,0, 3,0));
      tbl.push_back(mk(1,8'h33,0,1,0, 3,0,0,0,0,0, 3,0));
      tbl.push_back(mk(1,8'h97,0,1,0, 4,1,8'h11,0,0,0, 3,0));
      tbl.push_back(mk(0,0,0,1,0,     4,1,8'h22,0,0,0, 3,0));
      tbl.push_back(mk(0,0,0,1,0,     4,1,8'h33,1,0,0, 3,0));
      tbl.push_back(mk(0,0,0,1,0,     0,0,0,0,0,0, 3,0));
      // same packet under backpressure, with a stray byte during drain
      tbl.push_back(mk(1,8'hAA,0,0,0, 1,0,0,0,0,0, 3,0));
      tbl.push_back(mk(1,8'h03,0,0,0, 2,0,0,0,0,0, 3,0));
      tbl.push_back(mk(1,8'h11,0,0,0, 2,0,0,0,0,0, 3,0));
      tbl.push_back(mk(1,8'h22,0,0,0, 2,0,0,0,0,0, 3,0));
      tbl.push_back(mk(1,8'h33,0,0,0, 3,0,0,0,0,0, 3,0));
      tbl.push_back(mk(1,8'h97,0,0,0, 4,1,8'h11,0,0,0, 3,0));
      tbl.push_back(mk(0,0,0,1,0,     4,1,8'h22,0,0,0, 3,0));
      tbl.push_back(mk(1,8'hAA,0,0,0, 4,1,8'h22,0,0,0, 3,0));
      tbl.push_back(mk(0,0,0,0,0,     4,1,8'h22,0,0,0, 3,0));
      tbl.push_back(mk(0,0,0,1,0,     4,1,8'h33,1,0,0, 3,0));
      tbl.push_back(mk(0,0,0,0,0,     4,1,8'h33,1,0,0, 3,0));
      tbl.push_back(mk(0,0,0,0,0,     4,1,8'h33,1,0,0, 3,0));
      tbl.push_back(mk(0,0,0,1,0,     0,0,0,0,0,0, 3,0));
      // bad checksum, then a one-byte good packet
      tbl.push_back(mk(1,8'hAA,0,0,0, 1,0,0,0,0,0, 3,0));
      tbl.push_back(mk(1,8'h02,0,0,0, 2,0,0,0,0,0, 2,0));
      tbl.push_back(mk(1,8'h10,0,0,0, 2,0,0,0,0,0, 2,0));
      tbl.push_back(mk(1,8'h20,0,0,0, 3,0,0,0,0,0, 2,0));
      tbl.push_back(mk(1,8'h00,0,0,0, 0,0,0,0,1,3, 2,0));
      tbl.push_back(mk(0,0,0,0,0,     0,0,0,0,0,3, 2,0));
      tbl.push_back(mk(1,8'hAA,0,0,0, 1,0,0,0,0,3, 2,0));
      tbl.push_back(mk(1,8'h01,0,0,0, 2,0,0,0,0,3, 1,0));
      tbl.push_back(mk(1,8'h55,0,0,0, 3,0,0,0,0,3, 1,0));
      tbl.push_back(mk(1,8'hAA,0,0,0, 4,1,8'h55,1,0,3, 1,0));
      tbl.push_back(mk(0,0,0,1,0,     0,0,0,0,0,3, 1,0));
      // noise, zero length, over-length
      tbl.push_back(mk(1,8'h5A,0,0,0, 0,0,0,0,0,3, 1,0));
      tbl.push_back(mk(1,8'h00,0,0,0, 0,0,0,0,0,3, 1,0));
      tbl.push_back(mk(1,8'hAA,0,0,0, 1,0,0,0,0,3, 1,0));
      tbl.push_back(mk(1,8'h00,0,0,0, 0,0,0,0,1,1, 1,0));
      tbl.push_back(mk(0,0,0,0,0,     0,0,0,0,0,1, 1,0));
      tbl.push_back(mk(1,8'hAA,0,0,0, 1,0,0,0,0,1, 1,0));
      tbl.push_back(mk(1,8'h11,0,0,0, 0,0,0,0,1,1, 1,0));
      tbl.push_back(mk(0,0,0,0,0,     0,0,0,0,0,1, 1,0));
      // parity select freeze, SOF with parity error ignored, max length, payload parity error
      tbl.push_back(mk(0,0,0,0,1,     0,0,0,0,0,1, 1,1));
      tbl.push_back(mk(1,8'hAA,1,0,1, 0,0,0,0,0,1, 1,1));
      tbl.push_back(mk(1,8'hAA,0,0,1, 1,0,0,0,0,1, 1,1));
      tbl.push_back(mk(1,8'h10,0,0,0, 2,0,0,0,0,1, 16,1));
      tbl.push_back(mk(1,8'h55,1,0,0, 0,0,0,0,1,0, 16,1));
      tbl.push_back(mk(0,0,0,0,0,     0,0,0,0,0,0, 16,0));

      #23;
      chk("rst.state", 32'(fsm_state), 32'd0);
      chk("rst.valid", 32'(PKT_VALID), 32'd0);
      chk("rst.err",   32'(PKT_ERR),   32'd0);
      chk("rst.code",  32'(ERR_CODE),  32'd0);
      chk("rst.len",   32'(PKT_LEN),   32'd0);
      chk("rst.par",   32'(PARITY),    32'd0);
      RST = 1'b1;
      step();

      foreach (tbl[i]) begin
         drive(tbl[i].rdy, tbl[i].d, tbl[i].pe, tbl[i].rd, tbl[i].ps);
         step();
         chk($sformatf("v%0d.state", i), 32'(fsm_state), 32'(tbl[i].st));
         chk($sformatf("v%0d.valid", i), 32'(PKT_VALID), 32'(tbl[i].v));
         if (tbl[i].v) chk($sformatf("v%0d.data", i), 32'(PKT_DATA), 32'(tbl[i].pd));
         chk($sformatf("v%0d.last", i), 32'(PKT_LAST), 32'(tbl[i].l));
         chk($sformatf("v%0d.err", i),  32'(PKT_ERR),  32'(tbl[i].e));
         chk($sformatf("v%0d.code", i), 32'(ERR_CODE), 32'(tbl[i].ec));
         chk($sformatf("v%0d.len", i),  32'(PKT_LEN),  32'(tbl[i].len));
         chk($sformatf("v%0d.par", i),  32'(PARITY),   32'(tbl[i].par));
      end
      drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

      // timeout: error strobe exactly TC cycles after the last byte
      send(8'hAA); send(8'h02); send(8'h10);
      hit = 0;
      for (int k = 1; k <= TC + 5; k++) begin
         step();
         if (PKT_ERR && hit == 0) hit = k;
      end
      chk("tmo.cycle", 32'(hit), 32'(TC));
      chk("tmo.code",  32'(ERR_CODE), 32'd2);
      chk("tmo.state", 32'(fsm_state), 32'd0);
      chk("tmo.pulse", 32'(PKT_ERR), 32'd0);

      // byte on the expiry cycle wins
      send(8'hAA); send(8'h02); send(8'h10);
      for (int k = 1; k < TC; k++) step();
      chk("exp.pre.state", 32'(fsm_state), 32'd2);
      chk("exp.pre.err",   32'(PKT_ERR),   32'd0);
      send(8'h20);
      chk("exp.state", 32'(fsm_state), 32'd3);
      chk("exp.err",   32'(PKT_ERR),   32'd0);
      send(8'hCE);
      chk("exp.valid", 32'(PKT_VALID), 32'd1);
      chk("exp.data",  32'(PKT_DATA),  32'h10);
      step();
      chk("exp.hold",  32'(PKT_DATA),  32'h10);

      // asynchronous reset during drain
      #3 RST = 1'b0;
      #1;
      chk("arst.valid", 32'(PKT_VALID), 32'd0);
      chk("arst.state", 32'(fsm_state), 32'd0);
      chk("arst.data",  32'(PKT_DATA),  32'd0);
      chk("arst.last",  32'(PKT_LAST),  32'd0);
      chk("arst.len",   32'(PKT_LEN),   32'd0);
      chk("arst.code",  32'(ERR_CODE),  32'd0);
      chk("arst.err",   32'(PKT_ERR),   32'd0);
      #2 RST = 1'b1;
      step();
      chk("post.state", 32'(fsm_state), 32'd0);
      chk("post.err",   32'(PKT_ERR),   32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_rx_pkt_ctrl.md
Name: uart_rx_pkt_ctrl

Overview:
- Packet-level controller that sits directly behind uart_rx.
- Drives the receiver's PARITY configuration and consumes its RX_DATA / RX_DATA_RDY byte stream.
- Parses framed packets (SOF, LEN, payload, checksum), buffers the payload, verifies it, then streams it to the downstream core over a valid/ready interface.
- Supervises inter-byte timeout and reports framing errors.

Parameters:
- CLK_FREQ, 125_000_000, system clock frequency in Hz.
- BAUD, 9600, line baud rate; used only for the timeout count.
- MAX_LEN, 16, maximum payload bytes (1..255); sets buffer depth.
- SOF_BYTE, 8'hAA, start-of-frame marker.
- TIMEOUT_BITS, 20, inter-byte timeout in bit periods. TIMEOUT_CYC = (CLK_FREQ/BAUD)*TIMEOUT_BITS (260,400 at the defaults).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- PAR_SEL  in  1  requested parity select, forwarded to uart_rx.
- RX_DATA  in  8  byte from uart_rx.
- RX_DATA_RDY  in  1  one-cycle strobe; RX_DATA is valid in the same cycle.
- RX_PAR_ERR  in  1  parity error flag, qualified by RX_DATA_RDY.
- PARITY  out  1  parity configuration to uart_rx.
- PKT_DATA  out  8  payload byte.
- PKT_VALID  out  1  PKT_DATA is valid.
- PKT_READY  in  1  downstream accepts a byte.
- PKT_LAST  out  1  marks the final payload byte; qualified by PKT_VALID.
- PKT_LEN  out  8  payload length of the current packet; stable while PKT_VALID is high.
- PKT_ERR  out  1  one-cycle error strobe.
- ERR_CODE  out  2  error cause, valid with PKT_ERR: 00 parity, 01 bad length, 10 timeout, 11 checksum.
- fsm_state  out  3  current state encoding, for debug.

Behaviour:
- Reset (RST=0, async): every output goes to 0. State = IDLE, PARITY = 0, counters and checksum cleared. Buffer contents are don't-care.
- States: IDLE=0, LEN=1, PAYLOAD=2, CSUM=3, DRAIN=4.
- "Byte" below means a cycle with RX_DATA_RDY=1.
- PARITY register: loads PAR_SEL every cycle while in IDLE; frozen in all other states, so a frame is never reconfigured mid-packet.
- IDLE:
  - Byte equal to SOF_BYTE with no parity error: go to LEN and clear the checksum.
  - Any other byte, or any byte with a parity error: ignored, no error reported.
- LEN:
  - Byte with value 0 or greater than MAX_LEN: PKT_ERR with ERR_CODE=01, go to IDLE.
  - Otherwise: latch PKT_LEN, checksum = byte, index = 0, go to PAYLOAD.
- PAYLOAD:
  - Each byte is written to buffer[index]; checksum += byte (mod 256); index increments.
  - After the byte at index PKT_LEN-1, go to CSUM.
- CSUM:
  - Check: (checksum + byte) mod 256 == 0.
  - Pass: go to DRAIN.
  - Fail: PKT_ERR with ERR_CODE=11, go to IDLE.
- Parity error in LEN, PAYLOAD or CSUM: PKT_ERR with ERR_CODE=00, go to IDLE. This takes priority over the length and checksum checks.
- Timeout:
  - Counter cleared on every byte and on entry to LEN.
  - Counts in LEN, PAYLOAD and CSUM.
  - On reaching TIMEOUT_CYC-1: PKT_ERR with ERR_CODE=10, go to IDLE.
  - If a byte arrives in the same cycle as expiry, the byte wins and the counter clears.
- DRAIN:
  - PKT_VALID rises in the cycle after the passing CSUM byte, with PKT_DATA = buffer[0].
  - A byte transfers on PKT_VALID & PKT_READY; the next byte is presented in the following cycle. Back-to-back transfers are sustained at 1 byte/cycle.
  - PKT_DATA and PKT_LAST are held stable while PKT_VALID=1 and PKT_READY=0.
  - PKT_LAST=1 exactly on beat PKT_LEN-1.
  - After the last transfer: PKT_VALID=0 in the next cycle, go to IDLE.
- UART bytes arriving in DRAIN are discarded silently; the SOF search resumes only in IDLE.
- PKT_ERR is a single-cycle pulse; ERR_CODE holds its value until the next error.
- Reset asserted mid-packet or mid-drain aborts immediately. No PKT_ERR is raised and PKT_VALID drops asynchronously.
- Buffer: MAX_LEN x 8, single write port and single read port, indexed by a counter of width clog2(MAX_LEN).

Optional Feature:
- Macro: UART_PKT_STATS_EN.
- When defined, two extra outputs are added:
  - PKT_GOOD_CNT [15:0]: increments on each completed drain.
  - PKT_ERR_CNT [15:0]: increments on each PKT_ERR.
  - Both reset to 0, saturate at 16'hFFFF, and neither wraps.
- When undefined, neither port nor any counter logic exists. All other behaviour is identical.

Test Plan:
- Good packet, PKT_READY tied to 1: bytes AA 03 11 22 33 97 -> PKT_VALID for 3 consecutive cycles with data 11, 22, 33. PKT_LAST only on 33, PKT_LEN=3, no PKT_ERR.
- Backpressure: same packet with PKT_READY toggling 1,0,0,1,... -> data is held stable while stalled, order 11, 22, 33 preserved, exactly 3 transfers.
- Bad checksum: AA 02 10 20 00 -> PKT_ERR with ERR_CODE=11, PKT_VALID never rises. A following good packet (AA 01 55 AA) is delivered correctly.
- Bad length and noise: 5A 00 AA 00 -> 5A ignored; PKT_ERR with ERR_CODE=01 on the 00 length byte. Then AA 11 with MAX_LEN=16 -> ERR_CODE=01.
- Timeout: AA 02 10, then silence for 260,400 cycles -> PKT_ERR with ERR_CODE=10 at expiry. A byte arriving on the expiry cycle instead -> no error.
- Parity and reset: RX_PAR_ERR=1 on a payload byte -> ERR_CODE=00. PAR_SEL toggled mid-packet -> PARITY unchanged until IDLE. RST pulsed low during DRAIN -> all outputs 0, state IDLE.
